// File: rtl/rv32i_ctrl_defs.sv
// Shared encodings for the RV32I multi-cycle sequencer: opcodes, states and
// the coarse opcode classes used to choose the execute path.
package rv32i_ctrl_defs;

   localparam logic [6:0] OP_LUI      = 7'b0110111;
   localparam logic [6:0] OP_AUIPC    = 7'b0010111;
   localparam logic [6:0] OP_JAL      = 7'b1101111;
   localparam logic [6:0] OP_JALR     = 7'b1100111;
   localparam logic [6:0] OP_BRANCH   = 7'b1100011;
   localparam logic [6:0] OP_LOAD     = 7'b0000011;
   localparam logic [6:0] OP_STORE    = 7'b0100011;
   localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_OP       = 7'b0110011;
   localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_DECODE  = 3'd1,
      ST_EXECUTE = 3'd2,
      ST_MEM     = 3'd3,
      ST_WB      = 3'd4,
      ST_HALT    = 3'd5,
      ST_TRAP    = 3'd6
   } state_e;

   typedef enum logic [1:0] {
      CAT_ALU_WB,
      CAT_PC_ONLY,
      CAT_MEMOP,
      CAT_SYS
   } op_cat_e;

   typedef struct packed {
      logic    legal;
      op_cat_e cat;
   } op_class_t;

   function automatic op_class_t classify(input logic [6:0] opc);
      op_class_t c;
      c.legal = 1'b1;
      c.cat   = CAT_SYS;
      case (opc)
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OP_IMM, OP_OP: c.cat = CAT_ALU_WB;
         OP_BRANCH, OP_MISC_MEM:                              c.cat = CAT_PC_ONLY;
         OP_LOAD, OP_STORE:                                   c.cat = CAT_MEMOP;
         OP_SYSTEM:                                           c.cat = CAT_SYS;
         default:                                             c.legal = 1'b0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory stall timer: counts stalled access cycles down from MAX_WAIT-1 and
// flags the last allowed stall cycle.
module mem_wait_timer #(
   parameter int MAX_WAIT = 16
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr,
   input  logic tick,
   output logic expired
);

   localparam int W = $clog2(MAX_WAIT);
   localparam logic [W-1:0] LOAD_VAL = W'(MAX_WAIT - 1);

   logic [W-1:0] cnt_q;

   // Holds at zero once expired; the sequencer leaves the access state then.
   always_ff @(posedge CLK) begin
      if (RST || clr)
         cnt_q <= LOAD_VAL;
      else if (tick && (cnt_q != '0))
         cnt_q <= cnt_q - W'(1);
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/insn_sequencer.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEM/WB with
// write strobes, memory handshake, halt/trap handling and a retire counter.
//
//   state   | meaning
//   FETCH   | instruction read at PC, IR loads on mem_ready
//   DECODE  | opcode legality check
//   EXECUTE | ALU/branch retire, or dispatch to MEM / HALT
//   MEM     | data access at ALU result, store retires on mem_ready
//   WB      | load result written back, retire
//   HALT    | stopped by debug request or SYSTEM, exits only on RST
//   TRAP    | illegal opcode or bus timeout, exits only on RST
module insn_sequencer
   import rv32i_ctrl_defs::*;
#(
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [6:0]       opcode,
   input  logic             mem_ready,
   input  logic             halt_req,
   output logic             ir_we,
   output logic             pc_we,
   output logic             rd_we,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic [2:0]       state,
   output logic             illegal,
   output logic             bus_err,
   output logic [CNT_W-1:0] insn_count
);

   state_e     state_q, state_next;
   op_class_t  cls;
   logic       is_store;
   logic       wait_tick, wait_clr, wait_expired;
   logic       set_illegal, set_bus_err;
   logic       ir_we_c, pc_we_c, rd_we_c, mem_req_c, mem_we_c, addr_sel_c;
   logic       illegal_q, bus_err_q;
   logic [CNT_W-1:0] count_q;

   assign cls      = classify(opcode);
   assign is_store = (opcode == OP_STORE);

   always_comb begin
      state_next  = state_q;
      ir_we_c     = 1'b0;
      pc_we_c     = 1'b0;
      rd_we_c     = 1'b0;
      mem_req_c   = 1'b0;
      mem_we_c    = 1'b0;
      addr_sel_c  = 1'b0;
      wait_tick   = 1'b0;
      set_illegal = 1'b0;
      set_bus_err = 1'b0;
      case (state_q)
         ST_FETCH: begin
            mem_req_c = 1'b1;
            if (mem_ready) begin
               ir_we_c    = 1'b1;
               state_next = ST_DECODE;
            end else begin
               wait_tick = 1'b1;
               if (wait_expired) begin
                  state_next  = ST_TRAP;
                  set_bus_err = 1'b1;
               end
            end
         end
         ST_DECODE: begin
            if (!cls.legal) begin
               state_next  = ST_TRAP;
               set_illegal = 1'b1;
            end else begin
               state_next = ST_EXECUTE;
            end
         end
         ST_EXECUTE: begin
            case (cls.cat)
               CAT_ALU_WB: begin
                  rd_we_c = 1'b1;
                  pc_we_c = 1'b1;
               end
               CAT_PC_ONLY: pc_we_c    = 1'b1;
               CAT_MEMOP:   state_next = ST_MEM;
               default:     state_next = ST_HALT;
            endcase
         end
         ST_MEM: begin
            mem_req_c  = 1'b1;
            addr_sel_c = 1'b1;
            mem_we_c   = is_store;
            if (mem_ready) begin
               if (is_store)
                  pc_we_c = 1'b1;
               else
                  state_next = ST_WB;
            end else begin
               wait_tick = 1'b1;
               if (wait_expired) begin
                  state_next  = ST_TRAP;
                  set_bus_err = 1'b1;
               end
            end
         end
         ST_WB: begin
            rd_we_c = 1'b1;
            pc_we_c = 1'b1;
         end
         ST_HALT, ST_TRAP: ;
         default: state_next = ST_TRAP;
      endcase
      // Every retire returns to FETCH unless a debug halt is pending.
      if (pc_we_c)
         state_next = halt_req ? ST_HALT : ST_FETCH;
   end

   assign wait_clr = (state_next != state_q);

   mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
      .CLK     (CLK),
      .RST     (RST),
      .clr     (wait_clr),
      .tick    (wait_tick),
      .expired (wait_expired)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= ST_FETCH;
         count_q   <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q <= state_next;
         if (pc_we_c)
            count_q <= count_q + CNT_W'(1);
         if (set_illegal)
            illegal_q <= 1'b1;
         if (set_bus_err)
            bus_err_q <= 1'b1;
      end
   end

   // Reset masks the strobes so an access in flight leaves no side effects.
   assign ir_we      = ir_we_c    & ~RST;
   assign pc_we      = pc_we_c    & ~RST;
   assign rd_we      = rd_we_c    & ~RST;
   assign mem_req    = mem_req_c  & ~RST;
   assign mem_we     = mem_we_c   & ~RST;
   assign addr_sel   = addr_sel_c & ~RST;
   assign state      = state_q;
   assign illegal    = illegal_q;
   assign bus_err    = bus_err_q;
   assign insn_count = count_q;

endmodule

// File: doc/insn_sequencer.md
Name: insn_sequencer

Overview:
- Multi-cycle control sequencer for the RV32I core.
- Steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB.
- Drives the write-enable strobes for the IR, PC and register file, plus the memory request handshake.
- Sits above the per-format instruction decoders, which still supply the datapath selects (ALU op, immediate, PC select).

Parameters:
MAX_WAIT, 16, cycles a memory access may stall before a bus-error trap (2..65535)
CNT_W, 32, width of the retired-instruction counter

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST  input  1  reset; synchronous, active-high
opcode  input  7  INSN[6:0] from the IR; valid from DECODE onward
mem_ready  input  1  memory access complete this cycle
halt_req  input  1  external debug halt request
ir_we  output  1  load IR this cycle
pc_we  output  1  update PC this cycle; equals the retire strobe
rd_we  output  1  register-file write this cycle
mem_req  output  1  memory access request
mem_we  output  1  memory write; only with mem_req in MEM
addr_sel  output  1  memory address source: 0 = PC, 1 = ALU result
state  output  3  current state (debug)
illegal  output  1  sticky: illegal opcode trapped
bus_err  output  1  sticky: memory timeout trapped
insn_count  output  CNT_W  retired-instruction count

Behaviour:
- Reset
  - RST is sampled on the CLK edge.
  - state <= FETCH; wait counter, insn_count, illegal and bus_err <= 0.
  - While RST is high, every strobe (ir_we, pc_we, rd_we, mem_req, mem_we) is forced to 0 and addr_sel to 0.
  - RST mid-access abandons the access with no IR, PC or register-file update.
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5, TRAP=6.
- Strobes are combinational from state, opcode and mem_ready.
- FETCH
  - mem_req=1, addr_sel=0.
  - On mem_ready: ir_we=1 in the same cycle, then go to DECODE.
  - Minimum latency is 1 cycle.
- DECODE
  - Recognised opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, MISC-MEM 0001111, SYSTEM 1110011.
  - Any other opcode: go to TRAP and set illegal.
  - Otherwise go to EXECUTE.
- EXECUTE
  - LUI, AUIPC, JAL, JALR, OP-IMM, OP: rd_we=1, pc_we=1, then FETCH.
  - BRANCH, MISC-MEM: pc_we=1, then FETCH.
  - LOAD, STORE: go to MEM.
  - SYSTEM: go to HALT with no retire.
- MEM
  - mem_req=1, addr_sel=1; mem_we=1 for STORE only.
  - On mem_ready: LOAD goes to WB; STORE asserts pc_we=1 and goes to FETCH.
- WB: rd_we=1, pc_we=1, then FETCH.
- Latencies with zero-stall memory: ALU/branch 3 cycles, store 4, load 5.
- Retire
  - insn_count increments by 1 on every cycle with pc_we=1.
  - Wraps modulo 2^CNT_W without any flag.
- halt_req
  - Checked only on a retiring transition to FETCH.
  - If asserted, go to HALT instead of FETCH; the retire still counts.
  - Never interrupts an in-flight access.
- Timeout
  - The wait counter increments on each FETCH or MEM cycle with mem_ready=0, and clears on any state change.
  - If the counter equals MAX_WAIT-1 and mem_ready=0: go to TRAP and set bus_err.
  - If mem_ready=1 in that same cycle, mem_ready wins and the access completes normally.
- HALT and TRAP
  - All strobes 0.
  - Absorbing; only RST exits.
  - illegal and bus_err are held until RST.

Decomposition:
- Shared package rv32i_ctrl_defs holds:
  - the 7-bit opcode localparams above;
  - the state encodings;
  - a 4-class opcode category (ALU_WB, PC_ONLY, MEMOP, SYS) used by DECODE and EXECUTE.
- Sub-module mem_wait_timer (parameter MAX_WAIT):
  - inputs: CLK, RST, clr, tick;
  - output: expired.
  - It is the only counter besides insn_count.

Test Plan:
- Reset, then AUIPC 0x12345117 with mem_ready=1 immediately -> ir_we in cycle 1; rd_we and pc_we in cycle 3 only; insn_count=1; mem_we never set.
- LW 0x0000A103 with mem_ready delayed 2 cycles in MEM -> mem_req and addr_sel=1 for 3 cycles, mem_we=0; WB cycle has rd_we=1, pc_we=1; 7 cycles total.
- SW 0x0020A023 -> MEM cycle has mem_req=1, mem_we=1, addr_sel=1, pc_we=1, rd_we=0; insn_count increments once.
- Opcode 0x7F (INSN 0x0000007F) -> TRAP on cycle 3 with illegal=1, no pc_we; remains in TRAP for 20 cycles; RST returns to FETCH with illegal=0.
- MAX_WAIT=16, mem_ready held 0 in FETCH -> TRAP with bus_err=1 after exactly 16 cycles. Repeat with mem_ready=1 on cycle 16 -> normal DECODE, bus_err=0.
- ADDI 0x00500093 retiring while halt_req=1 -> state HALT, insn_count=1. ECALL 0x00000073 -> HALT, insn_count unchanged. RST asserted during a MEM stall -> FETCH next cycle with no rd_we or pc_we.
